// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder built around one 1-bit full-adder cell. It processes one
//   bit per clock, LSB first. The result registers (sum/cout/overflow) are
//   written only when the final bit completes. Until then they keep the
//   previous result, and all partial shifting happens in an internal
//   accumulator.
//
// Parameters
//   WIDTH    : operand width in bits (2..32)
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request an addition; accepted while ready=1
//   a, b     : operands, sampled in the accept cycle only
//   cin      : carry-in, sampled in the accept cycle only
//   ready    : start will be accepted this cycle
//   busy     : bits are being added
//   done     : one-cycle pulse, result valid
//   sum      : WIDTH-bit result
//   cout     : carry out of bit WIDTH-1
//   overflow : signed overflow (carry into MSB xor carry out of MSB)

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state, state_n;
   logic             load, step, last;

   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] acc;       // sum bits assembled so far; the newest bit enters at the top
   logic [WIDTH-1:0] acc_n;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_c;

   // The single full-adder cell
   assign fa_s  = a_sh[0] ^ b_sh[0] ^ carry;
   assign fa_c  = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
   assign acc_n = {fa_s, acc};
   assign last  = (cnt == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state and control outputs
   always_comb begin
      state_n = IDLE;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            step    = 1'b1;
            state_n = last ? DONE : RUN;
         end
         DONE: begin
            done  = 1'b1;
            ready = 1'b1;
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (load) begin
         a_sh  <= a;
         b_sh  <= b;
         acc   <= '0;
         carry <= cin;
         cnt   <= '0;
      end else if (step) begin
         a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
         acc   <= acc_n[WIDTH-1:1];
         carry <= fa_c;
         cnt   <= cnt + 1'b1;
         if (last) begin
            // carry still holds the carry into the MSB for this bit
            sum      <= acc_n;
            cout     <= fa_c;
            overflow <= carry ^ fa_c;
         end
      end
   end

endmodule
